// File: rtl/trap_ctrl.sv
// Commit-side trap/return/CSR sequencer: arbitrates one committing instruction,
// then walks the trap, mret or CSR access sequence and issues the redirect.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmt_valid,
    input  logic [63:0] cmt_pc,
    input  logic        cmt_ecall,
    input  logic        cmt_mret,
    input  logic [1:0]  cmt_csr_op,
    input  logic [11:0] cmt_csr_idx,
    input  logic [63:0] cmt_csr_src,
    input  logic        tmr_irq,
    input  logic [63:0] csr_rdata,
    input  logic        ex_stall,
    output logic        cmt_ready,
    output logic        csr_rd_en,
    output logic        csr_wr_en,
    output logic [11:0] csr_idx,
    output logic [63:0] wbck_csr_data,
    output logic        trap_ena,
    output logic [63:0] trap_mcause_value,
    output logic        cmt_mret_ena,
    output logic        rd_valid,
    output logic [63:0] rd_data,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        flush,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRAP, S_VEC, S_RET, S_CSR, S_JUMP
    } state_t;

    localparam logic [63:0] CAUSE_TMR   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL = 64'h0000_0000_0000_000B;
    localparam logic [11:0] IDX_MTVEC   = 12'h305;
    localparam logic [11:0] IDX_MEPC    = 12'h341;

    state_t      state_q, state_d;
    logic [63:0] save_pc_q, save_pc_d;
    logic [63:0] cause_q, cause_d;
    logic [63:0] target_q, target_d;
    logic [1:0]  op_q, op_d;
    logic [11:0] idx_q, idx_d;
    logic [63:0] src_q, src_d;
    logic [64:0] csr_wr;

    // Returns {write_enable, write_data}; set/clear with a zero mask leave the CSR untouched.
    function automatic logic [64:0] csr_wr_calc(input logic [1:0] op,
                                                input logic [63:0] rdata,
                                                input logic [63:0] src);
        case (op)
            2'b01:   return {1'b1, src};
            2'b10:   return {src != 64'd0, rdata | src};
            2'b11:   return {src != 64'd0, rdata & ~src};
            default: return 65'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            save_pc_q <= 64'd0;
            cause_q   <= 64'd0;
            target_q  <= 64'd0;
            op_q      <= 2'd0;
            idx_q     <= 12'd0;
            src_q     <= 64'd0;
        end else begin
            state_q   <= state_d;
            save_pc_q <= save_pc_d;
            cause_q   <= cause_d;
            target_q  <= target_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            src_q     <= src_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        save_pc_d = save_pc_q;
        cause_d   = cause_q;
        target_d  = target_q;
        op_d      = op_q;
        idx_d     = idx_q;
        src_d     = src_q;
        if (!ex_stall) begin
            case (state_q)
                S_IDLE: begin
                    if (cmt_valid) begin
                        if (tmr_irq && (cmt_pc != 64'd0)) begin
                            save_pc_d = cmt_pc;
                            cause_d   = CAUSE_TMR;
                            state_d   = S_TRAP;
                        end else if (cmt_ecall) begin
                            save_pc_d = cmt_pc;
                            cause_d   = CAUSE_ECALL;
                            state_d   = S_TRAP;
                        end else if (cmt_mret) begin
                            state_d   = S_RET;
                        end else if (cmt_csr_op != 2'b00) begin
                            op_d      = cmt_csr_op;
                            idx_d     = cmt_csr_idx;
                            src_d     = cmt_csr_src;
                            state_d   = S_CSR;
                        end
                    end
                end
                S_TRAP:  state_d = S_VEC;
                S_VEC, S_RET: begin
                    target_d = {csr_rdata[63:2], 2'b00};
                    state_d  = S_JUMP;
                end
                S_CSR:   state_d = S_IDLE;
                S_JUMP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign csr_wr = csr_wr_calc(op_q, csr_rdata, src_q);

    // Everything is silenced while reset is asserted or the pipeline is frozen.
    always_comb begin
        cmt_ready         = 1'b0;
        csr_rd_en         = 1'b0;
        csr_wr_en         = 1'b0;
        csr_idx           = 12'd0;
        wbck_csr_data     = 64'd0;
        trap_ena          = 1'b0;
        trap_mcause_value = 64'd0;
        cmt_mret_ena      = 1'b0;
        rd_valid          = 1'b0;
        rd_data           = 64'd0;
        redirect_valid    = 1'b0;
        redirect_pc       = 64'd0;
        flush             = 1'b0;
        busy              = !rst && (state_q != S_IDLE);
        if (!rst && !ex_stall) begin
            case (state_q)
                S_IDLE: cmt_ready = 1'b1;
                S_TRAP: begin
                    trap_ena          = 1'b1;
                    trap_mcause_value = cause_q;
                    wbck_csr_data     = save_pc_q;
                end
                S_VEC: begin
                    csr_rd_en = 1'b1;
                    csr_idx   = IDX_MTVEC;
                end
                S_RET: begin
                    cmt_mret_ena = 1'b1;
                    csr_rd_en    = 1'b1;
                    csr_idx      = IDX_MEPC;
                end
                S_CSR: begin
                    csr_rd_en     = 1'b1;
                    csr_idx       = idx_q;
                    rd_valid      = 1'b1;
                    rd_data       = csr_rdata;
                    csr_wr_en     = csr_wr[64];
                    wbck_csr_data = csr_wr[64] ? csr_wr[63:0] : 64'd0;
                end
                S_JUMP: begin
                    redirect_valid = 1'b1;
                    flush          = 1'b1;
                    redirect_pc    = target_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model that schedules expected steps.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_valid;
    logic [63:0] cmt_pc;
    logic        cmt_ecall;
    logic        cmt_mret;
    logic [1:0]  cmt_csr_op;
    logic [11:0] cmt_csr_idx;
    logic [63:0] cmt_csr_src;
    logic        tmr_irq;
    logic [63:0] csr_rdata;
    logic        ex_stall;
    logic        cmt_ready, csr_rd_en, csr_wr_en, trap_ena, cmt_mret_ena;
    logic        rd_valid, redirect_valid, flush, busy;
    logic [11:0] csr_idx;
    logic [63:0] wbck_csr_data, trap_mcause_value, rd_data, redirect_pc;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_ecall(cmt_ecall),
        .cmt_mret(cmt_mret), .cmt_csr_op(cmt_csr_op), .cmt_csr_idx(cmt_csr_idx),
        .cmt_csr_src(cmt_csr_src), .tmr_irq(tmr_irq), .csr_rdata(csr_rdata),
        .ex_stall(ex_stall), .cmt_ready(cmt_ready), .csr_rd_en(csr_rd_en),
        .csr_wr_en(csr_wr_en), .csr_idx(csr_idx), .wbck_csr_data(wbck_csr_data),
        .trap_ena(trap_ena), .trap_mcause_value(trap_mcause_value),
        .cmt_mret_ena(cmt_mret_ena), .rd_valid(rd_valid), .rd_data(rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum {K_TRAP, K_VEC, K_RET, K_CSR, K_JUMP} step_e;
    step_e       sched[$];
    logic [63:0] m_pc, m_cause, m_target, m_src;
    logic [1:0]  m_op;
    logic [11:0] m_idx;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic        e_ready = 0, e_rd = 0, e_wr = 0, e_trap = 0, e_mret = 0;
        logic        e_rdv = 0, e_redir = 0, e_flush = 0, e_busy = 0;
        logic [11:0] e_idx = 0;
        logic [63:0] e_wbck = 0, e_cause = 0, e_rdata = 0, e_rpc = 0, res;
        logic        we;
        if (!rst) begin
            e_busy = sched.size() != 0;
            if (!ex_stall) begin
                if (sched.size() == 0) e_ready = 1;
                else case (sched[0])
                    K_TRAP: begin e_trap = 1; e_cause = m_cause; e_wbck = m_pc; end
                    K_VEC:  begin e_rd = 1; e_idx = 12'h305; end
                    K_RET:  begin e_mret = 1; e_rd = 1; e_idx = 12'h341; end
                    K_JUMP: begin e_redir = 1; e_flush = 1; e_rpc = m_target; end
                    K_CSR: begin
                        e_rd = 1; e_idx = m_idx; e_rdv = 1; e_rdata = csr_rdata;
                        if (m_op == 2'b01)      begin res = m_src;              we = 1; end
                        else if (m_op == 2'b10) begin res = csr_rdata | m_src;  we = (m_src != 0); end
                        else                    begin res = csr_rdata & ~m_src; we = (m_src != 0); end
                        e_wr = we;
                        e_wbck = we ? res : 64'd0;
                    end
                endcase
            end
        end
        chk("cmt_ready", cmt_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("csr_rd_en", csr_rd_en, e_rd);
        chk("csr_wr_en", csr_wr_en, e_wr);
        chk("csr_idx", csr_idx, e_idx);
        chk("wbck", wbck_csr_data, e_wbck);
        chk("trap_ena", trap_ena, e_trap);
        chk("mcause", trap_mcause_value, e_cause);
        chk("mret_ena", cmt_mret_ena, e_mret);
        chk("rd_valid", rd_valid, e_rdv);
        chk("rd_data", rd_data, e_rdata);
        chk("redirect_valid", redirect_valid, e_redir);
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("flush", flush, e_flush);
    endtask

    task automatic update_model();
        step_e s;
        if (rst) begin
            sched.delete();
            m_pc = 0; m_cause = 0; m_target = 0; m_src = 0; m_op = 0; m_idx = 0;
        end else if (!ex_stall) begin
            if (sched.size() != 0) begin
                s = sched.pop_front();
                if (s == K_VEC || s == K_RET) m_target = csr_rdata & ~64'd3;
            end else if (cmt_valid) begin
                if (tmr_irq && cmt_pc != 0) begin
                    m_pc = cmt_pc; m_cause = 64'h8000_0000_0000_0007;
                    sched = '{K_TRAP, K_VEC, K_JUMP};
                end else if (cmt_ecall) begin
                    m_pc = cmt_pc; m_cause = 64'hB;
                    sched = '{K_TRAP, K_VEC, K_JUMP};
                end else if (cmt_mret) begin
                    sched = '{K_RET, K_JUMP};
                end else if (cmt_csr_op != 0) begin
                    m_op = cmt_csr_op; m_idx = cmt_csr_idx; m_src = cmt_csr_src;
                    sched = '{K_CSR};
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_model();
        update_model();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic idle_in();
        cmt_valid = 0; cmt_pc = 0; cmt_ecall = 0; cmt_mret = 0; cmt_csr_op = 0;
        cmt_csr_idx = 0; cmt_csr_src = 0; tmr_irq = 0; csr_rdata = 0; ex_stall = 0;
    endtask

    logic [1:0]  csr_ops [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [63:0] csr_srcs[4] = '{64'h0F, 64'h0F, 64'h0F, 64'h0};
    logic [63:0] csr_exp [4] = '{64'h0F, 64'hFF, 64'hF0, 64'h0};
    logic        csr_we  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        idle_in();
        rst = 1;
        sample(); chk("reset_ready", cmt_ready, 0); adv();
        step();
        rst = 0;
        sample(); chk("ready_after_reset", cmt_ready, 1); adv();

        // Ecall: trap, vector read, redirect.
        cmt_valid = 1; cmt_ecall = 1; cmt_pc = 64'h8000_0010;
        step();
        idle_in();
        sample(); chk("ecall_trap_ena", trap_ena, 1); chk("ecall_mcause", trap_mcause_value, 64'hB);
        chk("ecall_wbck", wbck_csr_data, 64'h8000_0010); adv();
        csr_rdata = 64'h8000_1001;
        sample(); chk("ecall_vec_idx", csr_idx, 12'h305); adv();
        csr_rdata = 0;
        sample(); chk("ecall_redirect_pc", redirect_pc, 64'h8000_1000); chk("ecall_flush", flush, 1); adv();
        sample(); chk("ecall_ready_T4", cmt_ready, 1); adv();

        // Interrupt beats ecall; interrupt at pc 0 is ignored.
        cmt_valid = 1; tmr_irq = 1; cmt_ecall = 1; cmt_pc = 64'h8000_0020;
        step();
        idle_in();
        sample(); chk("irq_mcause", trap_mcause_value, 64'h8000_0000_0000_0007);
        chk("irq_wbck", wbck_csr_data, 64'h8000_0020); adv();
        step(); step();
        cmt_valid = 1; tmr_irq = 1; cmt_pc = 0;
        step();
        idle_in();
        sample(); chk("irq_pc0_busy", busy, 0); chk("irq_pc0_trap", trap_ena, 0); adv();

        // Mret.
        cmt_valid = 1; cmt_mret = 1;
        step();
        idle_in(); csr_rdata = 64'h8000_0024;
        sample(); chk("mret_ena", cmt_mret_ena, 1); chk("mret_idx", csr_idx, 12'h341); adv();
        csr_rdata = 0;
        sample(); chk("mret_redirect_pc", redirect_pc, 64'h8000_0024); adv();

        // CSR ops on 0x340.
        for (int i = 0; i < 4; i++) begin
            idle_in();
            cmt_valid = 1; cmt_csr_op = csr_ops[i]; cmt_csr_idx = 12'h340; cmt_csr_src = csr_srcs[i];
            step();
            idle_in(); csr_rdata = 64'hF0;
            sample();
            chk($sformatf("csr%0d_rd_valid", i), rd_valid, 1);
            chk($sformatf("csr%0d_rd_data", i), rd_data, 64'hF0);
            chk($sformatf("csr%0d_wr_en", i), csr_wr_en, csr_we[i]);
            chk($sformatf("csr%0d_wbck", i), wbck_csr_data, csr_exp[i]);
            chk($sformatf("csr%0d_idx", i), csr_idx, 12'h340);
            adv();
        end
        idle_in();

        // Stall for three cycles in VEC, then resume.
        cmt_valid = 1; cmt_ecall = 1; cmt_pc = 64'h8000_0040;
        step();
        idle_in();
        step();
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            sample(); chk("stall_rd_en", csr_rd_en, 0); chk("stall_busy", busy, 1); adv();
        end
        ex_stall = 0; csr_rdata = 64'h8000_2003;
        sample(); chk("resume_vec_rd", csr_rd_en, 1); chk("resume_vec_idx", csr_idx, 12'h305); adv();
        csr_rdata = 0;
        sample(); chk("resume_redirect_pc", redirect_pc, 64'h8000_2000); adv();

        // Reset while in RET discards the redirect.
        cmt_valid = 1; cmt_mret = 1;
        step();
        idle_in(); rst = 1;
        sample(); chk("rst_ret_redirect", redirect_valid, 0); adv();
        rst = 0;
        sample(); chk("rst_ret_idle", cmt_ready, 1); chk("rst_ret_no_redirect", redirect_valid, 0); adv();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cmt_valid   = $urandom_range(0, 1);
            cmt_pc      = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            tmr_irq     = ($urandom_range(0, 3) == 0);
            cmt_ecall   = ($urandom_range(0, 3) == 0);
            cmt_mret    = ($urandom_range(0, 3) == 0);
            cmt_csr_op  = 2'($urandom_range(0, 3));
            cmt_csr_idx = 12'($urandom);
            cmt_csr_src = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            csr_rdata   = {$urandom, $urandom};
            ex_stall    = ($urandom_range(0, 6) == 0);
            rst         = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
